// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB requester: queued register commands issued as APB transfers
//
// Accepts read/write commands into a small FIFO and performs them back-to-back
// as APB transfers. Every completed transfer (PREADY or timeout) returns one
// response.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = FIFO not full)
//   cmd_write/cmd_addr/cmd_wdata  command direction, address, write data
//   rsp_valid                     one-cycle pulse per completed transfer
//   rsp_write/rsp_rdata/rsp_err   direction, read data, timeout flag
//   busy                          FSM active or commands still queued
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  registered APB requester outputs
//   PRDATA/PREADY                 APB completer inputs
module apb_requester #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_write,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       PREADY
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t r_state;
  state_t w_next;

  // Command storage; entries need no reset because r_count gates every read.
  logic                       r_fifo_write [FIFO_DEPTH];
  logic [AMBA_ADDR_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
  logic [AMBA_WORD-1:0]       r_fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [PTR_W:0]             r_count;

  logic [CNT_W-1:0]           r_tcnt;

  logic                       r_psel;
  logic                       r_penable;
  logic                       r_pwrite;
  logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
  logic [AMBA_WORD-1:0]       r_pwdata;

  logic                       r_rsp_valid;
  logic                       r_rsp_write;
  logic [AMBA_WORD-1:0]       r_rsp_rdata;
  logic                       r_rsp_err;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_done;
  logic w_timeout;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  // A full FIFO never accepts, even if a pop frees a slot in the same cycle.
  assign w_push  = cmd_valid && !w_full;

  // Held low while reset is asserted so no command appears accepted then.
  assign cmd_ready = rst && !w_full;
  assign busy      = (r_state != S_IDLE) || !w_empty;

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_write[r_wr_ptr] <= cmd_write;
      r_fifo_addr[r_wr_ptr]  <= cmd_addr;
      r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are power-of-2 wide, so the increment wraps by itself.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_SETUP;
        end
      end
      S_SETUP: begin
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY || (r_tcnt == TO_LAST)) begin
          w_done    = 1'b1;
          w_timeout = !PREADY;
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = S_SETUP;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // APB outputs are registered from the next state so they line up with it;
  // address/data/direction only change on a pop and are otherwise held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_tcnt      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_psel    <= (w_next != S_IDLE);
      r_penable <= (w_next == S_ACCESS);
      if (w_pop) begin
        r_pwrite <= r_fifo_write[r_rd_ptr];
        r_paddr  <= r_fifo_addr[r_rd_ptr];
        r_pwdata <= r_fifo_wdata[r_rd_ptr];
      end

      if (r_state == S_SETUP) begin
        r_tcnt <= '0;
      end else if ((r_state == S_ACCESS) && !w_done) begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      // PRDATA is only captured on a successful read completion.
      r_rsp_valid <= w_done;
      r_rsp_write <= w_done && r_pwrite;
      r_rsp_rdata <= (w_done && PREADY && !r_pwrite) ? PRDATA : '0;
      r_rsp_err   <= w_timeout;
    end
  end

endmodule
